// File: rtl/twpm_pkg.sv
// Shared constants and types for the TPM mailbox: register offsets, FSM encoding, default read data.
package twpm_pkg;

    localparam logic [31:0] DFLT_READ_VALUE = 32'hBADF_ABAC;

    localparam int unsigned REG_STATUS   = 'h00;
    localparam int unsigned REG_OP_TYPE  = 'h04;
    localparam int unsigned REG_LOCALITY = 'h08;
    localparam int unsigned REG_BUF_SIZE = 'h0C;
    localparam int unsigned REG_COMPLETE = 'h40;

    localparam int unsigned PULSE_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } twpm_state_e;

endpackage

// File: rtl/twpm_tpm_mailbox_if.sv
// Wishbone classic bus between the CPU master and the TPM mailbox slave.
interface twpm_tpm_mailbox_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/twpm_pulse_gen.sv
// Fixed-width pulse generator: a load starts a WIDTH-cycle pulse, loads while busy are ignored.
module twpm_pulse_gen
    import twpm_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic load_i,
    output logic pulse_o,
    output logic busy_o
);

    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;

    // Count down to zero and saturate; only an idle counter accepts a load.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_CNT_W'(1);
        end else if (load_i) begin
            cnt_d = PULSE_CNT_W'(WIDTH);
        end
        pulse_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/twpm_tpm_mailbox.sv
// Wishbone slave for the TPM register window and command/response RAM; gates RAM access on exec_i.
module twpm_tpm_mailbox
    import twpm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS         = 32'hF000_0000,
    parameter int unsigned REGS_ADDR_WIDTH      = 11,
    parameter int unsigned RAM_ADDR_WIDTH       = 11,
    parameter int unsigned COMPLETE_PULSE_WIDTH = 20,
    parameter logic [31:0] DEFAULT_READ_VALUE   = DFLT_READ_VALUE
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    twpm_tpm_mailbox_if.slave         wb,
    input  logic                      exec_i,
    input  logic                      abort_i,
    input  logic [3:0]                op_type_i,
    input  logic [3:0]                locality_i,
    input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
    output logic                      complete_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_a_o,
    output logic [31:0]               ram_wd_o,
    output logic [3:0]                ram_wen_o,
    input  logic [31:0]               ram_rd_i
);

    localparam int unsigned RAM_AW   = RAM_ADDR_WIDTH - 2;
    localparam logic [32:0] REG_SPAN = 33'(1) << REGS_ADDR_WIDTH;
    localparam logic [32:0] RAM_END  = REG_SPAN + (33'(1) << RAM_ADDR_WIDTH);

    twpm_state_e                state_q, state_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic                       err_pend_q, err_pend_d;
    logic [31:0]                dat_q, dat_d;
    logic [RAM_AW-1:0]          ram_a_q, ram_a_d;
    logic [31:0]                ram_wd_q, ram_wd_d;
    logic [3:0]                 ram_wen_q, ram_wen_d;

    logic [31:0]                off;
    logic                       reg_hit, ram_hit, access;
    logic [REGS_ADDR_WIDTH-1:0] reg_off;
    logic [RAM_AW-1:0]          ram_word;
    logic [31:0]                reg_rdata;
    logic                       pulse_load, pulse_busy;

    // Window decode relative to BASE_ADDRESS; addresses below base wrap and miss both windows.
    assign off      = wb.wb_adr_i - BASE_ADDRESS;
    assign reg_hit  = ({1'b0, off} < REG_SPAN);
    assign ram_hit  = !reg_hit && ({1'b0, off} < RAM_END);
    assign access   = wb.wb_cyc_i && wb.wb_stb_i;
    assign reg_off  = {off[REGS_ADDR_WIDTH-1:2], 2'b00};
    assign ram_word = RAM_AW'((off - REG_SPAN[31:0]) >> 2);

    always_comb begin
        reg_rdata = DEFAULT_READ_VALUE;
        if (reg_off == REGS_ADDR_WIDTH'(REG_STATUS)) begin
            reg_rdata = {29'd0, complete_o, abort_i, exec_i};
        end else if (reg_off == REGS_ADDR_WIDTH'(REG_OP_TYPE)) begin
            reg_rdata = {28'd0, op_type_i};
        end else if (reg_off == REGS_ADDR_WIDTH'(REG_LOCALITY)) begin
            reg_rdata = {28'd0, locality_i};
        end else if (reg_off == REGS_ADDR_WIDTH'(REG_BUF_SIZE)) begin
            reg_rdata = 32'(buf_len_i);
        end
    end

    // Transaction FSM; RESP raises ack/err once and holds off new accesses until it has dropped.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        err_pend_d = err_pend_q;
        dat_d      = dat_q;
        ram_a_d    = ram_a_q;
        ram_wd_d   = ram_wd_q;
        ram_wen_d  = '0;
        pulse_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    err_pend_d = 1'b0;
                    state_d    = ST_RESP;
                    if (reg_hit) begin
                        if (!wb.wb_we_i) begin
                            dat_d = reg_rdata;
                        end else if (reg_off == REGS_ADDR_WIDTH'(REG_COMPLETE)) begin
                            pulse_load = exec_i && !pulse_busy;
                        end
                    end else if (ram_hit) begin
                        if (exec_i) begin
                            ram_a_d = ram_word;
                            if (wb.wb_we_i) begin
                                ram_wd_d  = wb.wb_dat_i;
                                ram_wen_d = wb.wb_sel_i;
                            end else begin
                                state_d = ST_RAM_RD;
                            end
                        end else if (!wb.wb_we_i) begin
                            dat_d = DEFAULT_READ_VALUE;
                        end
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
            end
            ST_RAM_RD: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    dat_d   = ram_rd_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!wb.wb_cyc_i || ack_q || err_q) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_d = !err_pend_q;
                    err_d = err_pend_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            dat_q      <= '0;
            ram_a_q    <= '0;
            ram_wd_q   <= '0;
            ram_wen_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            dat_q      <= dat_d;
            ram_a_q    <= ram_a_d;
            ram_wd_q   <= ram_wd_d;
            ram_wen_q  <= ram_wen_d;
        end
    end

    twpm_pulse_gen #(
        .WIDTH (COMPLETE_PULSE_WIDTH)
    ) u_pulse_gen (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .load_i  (pulse_load),
        .pulse_o (complete_o),
        .busy_o  (pulse_busy)
    );

    // The RAM samples the address on the accepting edge so read data is ready one cycle later.
    assign ram_a_o     = ram_a_d;
    assign ram_wd_o    = ram_wd_q;
    assign ram_wen_o   = exec_i ? ram_wen_q : 4'b0000;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_twpm_tpm_mailbox.sv
// Randomised bench for twpm_tpm_mailbox against a transaction-level model of registers and RAM.
module tb_twpm_tpm_mailbox;

    localparam logic [31:0] BASE    = 32'hF000_0000;
    localparam logic [31:0] RAMBASE = 32'hF000_0800;
    localparam logic [31:0] DFLT    = 32'hBADF_ABAC;

    logic        clk;
    logic        rstn;
    logic        exec;
    logic        abort;
    logic [3:0]  op_type;
    logic [3:0]  locality;
    logic [10:0] buf_len;
    logic        complete;
    logic [8:0]  ram_a;
    logic [31:0] ram_wd;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rd;

    twpm_tpm_mailbox_if bus ();

    twpm_tpm_mailbox dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .wb         (bus.slave),
        .exec_i     (exec),
        .abort_i    (abort),
        .op_type_i  (op_type),
        .locality_i (locality),
        .buf_len_i  (buf_len),
        .complete_o (complete),
        .ram_a_o    (ram_a),
        .ram_wd_o   (ram_wd),
        .ram_wen_o  (ram_wen),
        .ram_rd_i   (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 512x32 RAM with one-cycle read latency.
    logic [31:0] mem [512];
    logic        mem_clr = 1'b0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
        end
        ram_rd <= mem[ram_a];
    end

    int          wen_cycles = 0;
    int          cmp_cycles = 0;
    logic [3:0]  last_wen   = 4'd0;
    logic [8:0]  last_wa    = 9'd0;
    always @(negedge clk) begin
        if (ram_wen != 4'd0) begin
            wen_cycles <= wen_cycles + 1;
            last_wen   <= ram_wen;
            last_wa    <= ram_a;
        end
        if (complete) cmp_cycles <= cmp_cycles + 1;
    end

    int          vec_cnt = 0;
    int          mis_cnt = 0;
    logic [31:0] ref_mem [512];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_reg(input logic [31:0] roff, input logic cmp);
        case (roff)
            32'h00:  return {29'd0, cmp, abort, exec};
            32'h04:  return {28'd0, op_type};
            32'h08:  return {28'd0, locality};
            32'h0C:  return {21'd0, buf_len};
            default: return DFLT;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Single classic transfer, started just after a rising edge; lat counts edges until ack/err.
    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel, input bit drop_exec,
                           output logic [31:0] rdat, output logic ack, output logic err, output int lat);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        rdat = 32'd0; ack = 1'b0; err = 1'b0; lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (drop_exec && n == 1) exec = 1'b0;
            if (bus.wb_ack_o || bus.wb_err_o) begin
                lat  = n;
                ack  = bus.wb_ack_o;
                err  = bus.wb_err_o;
                rdat = bus.wb_dat_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk); #1;
        chk("single_cycle_resp", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        ak, er;
    int          lt;
    int          w0, c0;

    initial begin
        rstn = 1'b0; exec = 1'b0; abort = 1'b0; op_type = 4'd0; locality = 4'd0; buf_len = 11'd0;
        bus.wb_adr_i = 32'd0; bus.wb_dat_i = 32'd0; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'd0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'd0;
        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_err", 32'(bus.wb_err_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_wen", 32'(ram_wen), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Status read
        exec = 1'b1; abort = 1'b0; op_type = 4'h9; locality = 4'h3; buf_len = 11'h5A5;
        wb_xfer(BASE, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("status_lat", 32'(lt), 32'd2);
        chk("status_ack", {31'd0, ak}, 32'd1);
        chk("status_err", {31'd0, er}, 32'd0);
        chk("status_dat", rd, 32'h0000_0001);
        for (int r = 1; r < 4; r++) begin
            wb_xfer(BASE + 32'(4*r), 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
            chk("reg_ro_dat", rd, ref_reg(32'(4*r), 1'b0));
        end

        // RAM write then read-back
        w0 = wen_cycles;
        wb_xfer(RAMBASE + 32'h4, 32'hDEAD_BEEF, 1'b1, 4'b0011, 1'b0, rd, ak, er, lt);
        ref_mem[1] = merge(ref_mem[1], 32'hDEAD_BEEF, 4'b0011);
        chk("ramwr_lat", 32'(lt), 32'd2);
        chk("ramwr_cycles", 32'(wen_cycles - w0), 32'd1);
        chk("ramwr_sel", 32'(last_wen), 32'b0011);
        chk("ramwr_addr", 32'(last_wa), 32'd1);
        chk("ramwr_data", ram_wd, 32'hDEAD_BEEF);
        wb_xfer(RAMBASE + 32'h4, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("ramrd_lat", 32'(lt), 32'd3);
        chk("ramrd_dat", rd, ref_mem[1]);

        // Gated RAM access, and exec falling during the write cycle
        exec = 1'b0;
        w0 = wen_cycles;
        wb_xfer(RAMBASE, 32'h1234_5678, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        chk("gated_wr_ack", {30'd0, ak, er}, 32'd2);
        chk("gated_wr_wen", 32'(wen_cycles - w0), 32'd0);
        wb_xfer(RAMBASE, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("gated_rd_ack", {30'd0, ak, er}, 32'd2);
        chk("gated_rd_dat", rd, DFLT);
        exec = 1'b1;
        wb_xfer(RAMBASE, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b1, rd, ak, er, lt);
        chk("execfall_wen", 32'(wen_cycles - w0), 32'd0);
        exec = 1'b1;
        wb_xfer(RAMBASE, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("execfall_dat", rd, ref_mem[0]);

        // Complete pulse: width, no extension, no pulse without exec
        c0 = cmp_cycles;
        wb_xfer(BASE + 32'h40, 32'd0, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        @(posedge clk); #1;
        wb_xfer(BASE + 32'h40, 32'h1, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        wb_xfer(BASE, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("status_busy", rd, 32'h0000_0005);
        for (int n = 0; n < 40 && complete; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("pulse_width", 32'(cmp_cycles - c0), 32'd20);
        exec = 1'b0;
        c0 = cmp_cycles;
        wb_xfer(BASE + 32'h40, 32'd0, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        chk("cmp_noexec_ack", {30'd0, ak, er}, 32'd2);
        repeat (25) @(posedge clk);
        #1;
        chk("cmp_noexec_pulse", 32'(cmp_cycles - c0), 32'd0);
        exec = 1'b1;
        c0 = cmp_cycles;
        wb_xfer(BASE + 32'h40, 32'd0, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        repeat (30) @(posedge clk);
        #1;
        chk("pulse_reload", 32'(cmp_cycles - c0), 32'd20);

        // Decode errors and unmapped register reads
        wb_xfer(32'hF000_1000, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("err_above", {30'd0, ak, er}, 32'd1);
        chk("err_lat", 32'(lt), 32'd2);
        wb_xfer(32'hEFFF_FFFC, 32'd0, 1'b1, 4'hF, 1'b0, rd, ak, er, lt);
        chk("err_below", {30'd0, ak, er}, 32'd1);
        wb_xfer(BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("unmapped_ack", {30'd0, ak, er}, 32'd2);
        chk("unmapped_dat", rd, DFLT);

        // Randomised mix against the transaction model
        for (int it = 0; it < 150; it++) begin
            logic [31:0] a, d, ex;
            logic [3:0]  s;
            int          k, wd;
            exec     = ($urandom_range(0, 3) != 0);
            abort    = 1'($urandom_range(0, 1));
            op_type  = 4'($urandom);
            locality = 4'($urandom);
            buf_len  = 11'($urandom);
            k = $urandom_range(0, 4);
            d = $urandom;
            s = 4'($urandom);
            wd = $urandom_range(0, 15);
            case (k)
                0: begin
                    a = 32'($urandom_range(0, 511)) * 32'd4;
                    ex = ref_reg(a, 1'b0);
                    wb_xfer(BASE + a + 32'($urandom_range(0, 3)), 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
                    chk("rnd_reg_ack", {30'd0, ak, er}, 32'd2);
                    chk("rnd_reg_lat", 32'(lt), 32'd2);
                    chk("rnd_reg_dat", rd, ex);
                end
                1: begin
                    wb_xfer(BASE + 32'h4, d, 1'b1, s, 1'b0, rd, ak, er, lt);
                    chk("rnd_ro_wr_ack", {30'd0, ak, er}, 32'd2);
                end
                2: begin
                    w0 = wen_cycles;
                    wb_xfer(RAMBASE + 32'(wd * 4), d, 1'b1, s, 1'b0, rd, ak, er, lt);
                    if (exec) ref_mem[wd] = merge(ref_mem[wd], d, s);
                    chk("rnd_ramwr_ack", {30'd0, ak, er}, 32'd2);
                    chk("rnd_ramwr_wen", 32'(wen_cycles - w0), (exec && s != 4'd0) ? 32'd1 : 32'd0);
                end
                3: begin
                    wb_xfer(RAMBASE + 32'(wd * 4), 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
                    chk("rnd_ramrd_ack", {30'd0, ak, er}, 32'd2);
                    chk("rnd_ramrd_dat", rd, exec ? ref_mem[wd] : DFLT);
                    if (exec) chk("rnd_ramrd_lat", 32'(lt), 32'd3);
                end
                default: begin
                    a = ($urandom_range(0, 1) != 0) ? (32'hF000_1000 + 32'($urandom_range(0, 4095))) : 32'hE000_0000;
                    wb_xfer(a, d, 1'($urandom_range(0, 1)), s, 1'b0, rd, ak, er, lt);
                    chk("rnd_err", {30'd0, ak, er}, 32'd1);
                end
            endcase
        end

        // Master abandons a RAM read
        exec = 1'b1;
        bus.wb_adr_i = RAMBASE + 32'h4; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        ak = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            ak = ak | bus.wb_ack_o | bus.wb_err_o;
        end
        chk("cyc_drop_noack", {31'd0, ak}, 32'd0);
        wb_xfer(RAMBASE + 32'h4, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("after_drop_lat", 32'(lt), 32'd3);
        chk("after_drop_dat", rd, ref_mem[1]);

        // Reset while the response is pending
        bus.wb_adr_i = BASE; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_ack", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
        chk("rst_resp_dat", bus.wb_dat_o, 32'd0);
        chk("rst_resp_outs", {complete, ram_wen, 23'd0} | 32'(ram_a), 32'd0);
        chk("rst_resp_wd", ram_wd, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        wb_xfer(BASE + 32'h8, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, er, lt);
        chk("post_rst_dat", rd, {28'd0, locality});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
